// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU, one-cycle ops plus a bit-serial shifter behind valid/ready.
// Define ALU_FAST_SHIFT_EN to replace the serial shifter with a one-cycle barrel shifter.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [4:0]       shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output logic             busy
);
   localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND = 4'b0000, OR = 4'b0001,
                          XOR = 4'b0011, NOR = 4'b1010, SLT = 4'b0111, LUI = 4'b0101,
                          SLL = 4'b1000, SRL = 4'b0100, SRA = 4'b1100;
   logic [WIDTH-1:0] sum, diff, res_c, ld_res;
   logic ovf_c, ill_c, load, ld_ovf, ld_ill;
   assign sum  = src_a + src_b;
   assign diff = src_a - src_b;
   always_comb begin
      res_c = '0;
      ovf_c = 1'b0;
      ill_c = 1'b0;
      case (alu_ctrl)
         ADD: begin
            res_c = sum;
            ovf_c = src_a[WIDTH-1] == src_b[WIDTH-1] && sum[WIDTH-1] != src_a[WIDTH-1];
         end
         SUB: begin
            res_c = diff;
            ovf_c = src_a[WIDTH-1] != src_b[WIDTH-1] && diff[WIDTH-1] != src_a[WIDTH-1];
         end
         AND: res_c = src_a & src_b;
         OR:  res_c = src_a | src_b;
         XOR: res_c = src_a ^ src_b;
         NOR: res_c = ~(src_a | src_b);
         SLT: res_c = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         LUI: res_c = {src_b[15:0], 16'h0};
`ifdef ALU_FAST_SHIFT_EN
         SLL: res_c = src_b << shamt;
         SRL: res_c = src_b >> shamt;
         SRA: res_c = $signed(src_b) >>> shamt;
`else
         // only reached with shamt == 0; nonzero amounts go through the serial path
         SLL, SRL, SRA: res_c = src_b;
`endif
         default: ill_c = 1'b1;
      endcase
   end
`ifdef ALU_FAST_SHIFT_EN
   assign in_ready = !out_valid || out_ready;
   assign busy     = 1'b0;
   assign load     = in_valid && in_ready;
   assign ld_res   = res_c;
   assign ld_ovf   = ovf_c;
   assign ld_ill   = ill_c;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] work, work_n, shifted;
   logic [4:0] cnt, cnt_n;
   logic [3:0] op, op_n;
   logic is_shift;
   assign is_shift = alu_ctrl == SLL || alu_ctrl == SRL || alu_ctrl == SRA;
   assign shifted  = op == SLL ? work << 1 : op == SRL ? work >> 1 : {work[WIDTH-1], work[WIDTH-1:1]};
   assign in_ready = state == IDLE && (!out_valid || out_ready);
   assign busy     = state == SHIFT;
   always_comb begin
      state_n = state;
      work_n  = work;
      cnt_n   = cnt;
      op_n    = op;
      load    = 1'b0;
      ld_res  = res_c;
      ld_ovf  = ovf_c;
      ld_ill  = ill_c;
      if (state == SHIFT) begin
         work_n = shifted;
         cnt_n  = cnt - 5'd1;
         if (cnt == 5'd1) begin
            state_n = IDLE;
            load    = 1'b1;
            ld_res  = shifted;
            ld_ovf  = 1'b0;
            ld_ill  = 1'b0;
         end
      end else if (in_valid && in_ready) begin
         if (is_shift && shamt != '0) begin
            state_n = SHIFT;
            work_n  = src_b;
            cnt_n   = shamt;
            op_n    = alu_ctrl;
         end else begin
            load = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         work  <= '0;
         cnt   <= '0;
         op    <= '0;
      end else begin
         state <= state_n;
         work  <= work_n;
         cnt   <= cnt_n;
         op    <= op_n;
      end
   end
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         out_valid <= load || (out_valid && !out_ready);
         if (load) begin
            result   <= ld_res;
            zero     <= ld_res == '0;
            overflow <= ld_ovf;
            illegal  <= ld_ill;
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a arithmetic reference model.
module tb_alu_exec_unit;
   localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND = 4'b0000, OR = 4'b0001,
                          XOR = 4'b0011, NOR = 4'b1010, SLT = 4'b0111, LUI = 4'b0101,
                          SLL = 4'b1000, SRL = 4'b0100, SRA = 4'b1100;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, zero, overflow, illegal, busy;
   logic [3:0] alu_ctrl = '0;
   logic [31:0] src_a = '0, src_b = '0, result, held;
   logic [4:0] shamt = '0;
   int tests = 0, fails = 0;
   logic [3:0] codes [12] = '{ADD, SUB, AND, OR, XOR, NOR, SLT, LUI, SLL, SRL, SRA, 4'b1111};

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
      .src_a(src_a), .src_b(src_b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .overflow(overflow), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // {illegal, overflow, result}, from signed 64-bit arithmetic rather than sign-bit rules
   function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] s);
      longint sa, sb, t, lim;
      logic [31:0] r;
      logic o, il;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lim = 64'sd2147483648;
      r = '0; o = 0; il = 0; t = 0;
      case (c)
         ADD: begin t = sa + sb; r = t[31:0]; o = t >= lim || t < -lim; end
         SUB: begin t = sa - sb; r = t[31:0]; o = t >= lim || t < -lim; end
         AND: r = a & b;
         OR:  r = a | b;
         XOR: r = a ^ b;
         NOR: r = ~(a | b);
         SLT: r = (sa < sb) ? 32'd1 : 32'd0;
         LUI: r = b * 32'd65536;
         SLL: r = b << s;
         SRL: r = b >> s;
         SRA: r = b[31] ? ~((~b) >> s) : b >> s;
         default: il = 1;
      endcase
      return {il, o, r};
   endfunction

   // called at a negedge with out_ready=1; returns at the negedge where out_valid is first seen
   task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
      logic [33:0] m;
      int n, lat, bad;
      m = model(c, a, b, s);
      lat = ((c == SLL || c == SRL || c == SRA) && s != 0) ? s + 1 : 1;
      chk({tag, " in_ready"}, in_ready, 1);
      in_valid = 1; alu_ctrl = c; src_a = a; src_b = b; shamt = s;
      @(negedge clk);
      // garbage requests while busy must be ignored
      in_valid = lat > 1; alu_ctrl = 4'($urandom); src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
      n = 1; bad = 0;
      while (!out_valid && n < 200) begin
         if (!busy || in_ready) bad++;
         @(negedge clk);
         n++;
      end
      in_valid = 0;
      chk({tag, " latency"}, n, lat);
      chk({tag, " busy/in_ready while shifting"}, bad, 0);
      chk({tag, " result"}, result, m[31:0]);
      chk({tag, " zero"}, zero, m[31:0] == 0);
      chk({tag, " overflow"}, overflow, m[32]);
      chk({tag, " illegal"}, illegal, m[33]);
      chk({tag, " busy at done"}, busy, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset result", result, 0);
      chk("reset zero", zero, 0);
      chk("reset overflow", overflow, 0);
      chk("reset illegal", illegal, 0);
      chk("reset busy", busy, 0);
      rst = 0;
      @(negedge clk);
      chk("in_ready after reset", in_ready, 1);

      do_op("add ovf", ADD, 32'h7FFFFFFF, 32'h1, 0);
      do_op("sub zero", SUB, 32'h1234, 32'h1234, 0);
      do_op("slt", SLT, 32'hFFFFFFFF, 32'h1, 0);
      do_op("sub ovf", SUB, 32'h80000000, 32'h1, 0);
      do_op("lui", LUI, 32'h0, 32'h0000ABCD, 0);
      do_op("nor", NOR, 32'h0, 32'h0, 0);
      do_op("sra 31", SRA, 32'h0, 32'h80000000, 31);
      do_op("sra 0", SRA, 32'h0, 32'h80000000, 0);
      do_op("sll 1", SLL, 32'h0, 32'h80000001, 1);
      do_op("illegal", 4'b1111, 32'h5, 32'h6, 0);

      // backpressure: hold the result, then drain and accept in the same cycle
      do_op("bp first", XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
      out_ready = 0;
      held = result;
      repeat (3) begin
         @(negedge clk);
         chk("bp out_valid held", out_valid, 1);
         chk("bp result held", result, held);
         chk("bp in_ready low", in_ready, 0);
      end
      out_ready = 1; in_valid = 1; alu_ctrl = ADD; src_a = 32'd100; src_b = 32'd23; shamt = 0;
      @(negedge clk);
      in_valid = 0;
      chk("bp new out_valid", out_valid, 1);
      chk("bp new result", result, 32'd123);
      @(negedge clk);
      chk("bp no duplicate", out_valid, 0);

      // reset part way through a long shift
      chk("mid-reset in_ready", in_ready, 1);
      in_valid = 1; alu_ctrl = SLL; src_b = 32'h3; shamt = 5'd20;
      @(negedge clk);
      in_valid = 0;
      repeat (4) @(negedge clk);
      chk("mid-reset busy before", busy, 1);
      rst = 1;
      @(negedge clk);
      chk("mid-reset out_valid", out_valid, 0);
      chk("mid-reset busy", busy, 0);
      chk("mid-reset result", result, 0);
      rst = 0;
      @(negedge clk);
      chk("mid-reset stays idle", out_valid, 0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] c;
         logic [4:0] s;
         c = codes[$urandom_range(0, 11)];
         s = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         do_op($sformatf("rand%0d", i), c, $urandom, $urandom, s);
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
